// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//   Instruction-fetch / program-counter stage of a single-cycle MIPS-32
//   datapath. Holds the PC, slices the instruction word returned by the
//   asynchronous-read instruction memory into control/register-file fields,
//   and selects the next PC from jump / branch / sequential candidates.
//   A three-state run-control FSM (IDLE -> RUN -> HALT) gates execution.
//
// Optional feature macro: FETCH_RETIRE_CNT_EN
//   When defined, adds the o_retired port with a saturating retired-instruction
//   counter. When undefined, the port and the counter do not exist.
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          asynchronous active-high reset
//   i_start        IDLE -> RUN request (ignored in RUN/HALT)
//   i_instr        instruction memory read data for address o_pc
//   i_branch       branch flag from control unit
//   i_zero         ALU zero flag
//   i_jump         jump flag from control unit
//   o_pc           current PC (registered)
//   o_instr_valid  fields describe a real instruction; qualifies write enables
//   o_opcode/o_rs/o_rt/o_rd/o_funct/o_imm  instruction fields (0 when invalid)
//   o_halted       FSM is in HALT
//   o_retired      retired-instruction count (FETCH_RETIRE_CNT_EN only)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter int unsigned         WIDTH_PC  = 32,
  parameter logic [WIDTH_PC-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WIDTH_PC-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [WIDTH_PC-1:0] i_instr,
  input  logic                i_branch,
  input  logic                i_zero,
  input  logic                i_jump,
  output logic [WIDTH_PC-1:0] o_pc,
  output logic                o_instr_valid,
  output logic [5:0]          o_opcode,
  output logic [4:0]          o_rs,
  output logic [4:0]          o_rt,
  output logic [4:0]          o_rd,
  output logic [5:0]          o_funct,
  output logic [15:0]         o_imm,
  output logic                o_halted
`ifdef FETCH_RETIRE_CNT_EN
  ,
  output logic [31:0]         o_retired
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH_PC-1:0] r_pc;
  logic [WIDTH_PC-1:0] w_pc_nxt;
  logic [WIDTH_PC-1:0] w_pc4;
  logic [WIDTH_PC-1:0] w_br_off;
  logic [WIDTH_PC-1:0] w_br_tgt;
  logic [WIDTH_PC-1:0] w_jmp_tgt;
  logic                w_valid;

  // All PC arithmetic is plain modulo-2^32 addition; wrap-around is intended.
  assign w_pc4     = r_pc + 32'd4;
  assign w_br_off  = {{14{i_instr[15]}}, i_instr[15:0], 2'b00};
  assign w_br_tgt  = w_pc4 + w_br_off;
  assign w_jmp_tgt = {w_pc4[31:28], i_instr[25:0], 2'b00};

  // State and PC registers with asynchronous reset to IDLE / RESET_PC.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Next-state, next-PC and instruction-valid decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // PC is pinned to RESET_PC so the first fetch in RUN is RESET_PC.
        w_pc_nxt = RESET_PC;
        if (i_start) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (i_instr == HALT_WORD) begin
          // PC freezes on the halt word's own address.
          w_state_nxt = ST_HALT;
        end else begin
          w_valid = 1'b1;
          if (i_jump) begin
            w_pc_nxt = w_jmp_tgt;
          end else if (i_branch && i_zero) begin
            w_pc_nxt = w_br_tgt;
          end else begin
            w_pc_nxt = w_pc4;
          end
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // Field slicing; everything reads as zero when no instruction is executing.
  always_comb begin
    o_opcode = 6'd0;
    o_rs     = 5'd0;
    o_rt     = 5'd0;
    o_rd     = 5'd0;
    o_funct  = 6'd0;
    o_imm    = 16'd0;
    if (w_valid) begin
      o_opcode = i_instr[31:26];
      o_rs     = i_instr[25:21];
      o_rt     = i_instr[20:16];
      o_rd     = i_instr[15:11];
      o_funct  = i_instr[5:0];
      o_imm    = i_instr[15:0];
    end else begin
      o_opcode = 6'd0;
    end
  end

  assign o_pc          = r_pc;
  assign o_instr_valid = w_valid;
  assign o_halted      = (r_state == ST_HALT);

`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] r_retired;

  // Saturating count of instructions retired (one per valid edge).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_retired <= 32'd0;
    end else if (w_valid && (r_retired != 32'hFFFF_FFFF)) begin
      r_retired <= r_retired + 32'd1;
    end
  end

  assign o_retired = r_retired;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_start;
  logic [31:0] i_instr;
  logic        i_branch;
  logic        i_zero;
  logic        i_jump;

  // dut0: RESET_PC = 0
  logic [31:0] pc0;
  logic        v0, h0;
  logic [5:0]  op0, fn0;
  logic [4:0]  rs0, rt0, rd0;
  logic [15:0] im0;
  // dut_hi: RESET_PC = 0x4000_0000
  logic [31:0] pc1;
  logic        v1, h1;
  logic [5:0]  op1, fn1;
  logic [4:0]  rs1, rt1, rd1;
  logic [15:0] im1;
  // dut_wr: RESET_PC = 0xFFFF_FFFC
  logic [31:0] pc2;
  logic        v2, h2;
  logic [5:0]  op2, fn2;
  logic [4:0]  rs2, rt2, rd2;
  logic [15:0] im2;
`ifdef FETCH_RETIRE_CNT_EN
  logic [31:0] ret0, ret1, ret2;
`endif

  logic [42:0] f0, f1, f2;
  assign f0 = {op0, rs0, rt0, rd0, fn0, im0};
  assign f1 = {op1, rs1, rt1, rd1, fn1, im1};
  assign f2 = {op2, rs2, rt2, rd2, fn2, im2};

  fetch_pc_unit #(.WIDTH_PC(32), .RESET_PC(32'h0000_0000), .HALT_WORD(32'hFFFF_FFFF)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_instr(i_instr),
    .i_branch(i_branch), .i_zero(i_zero), .i_jump(i_jump),
    .o_pc(pc0), .o_instr_valid(v0), .o_opcode(op0), .o_rs(rs0), .o_rt(rt0),
    .o_rd(rd0), .o_funct(fn0), .o_imm(im0), .o_halted(h0)
`ifdef FETCH_RETIRE_CNT_EN
    , .o_retired(ret0)
`endif
  );

  fetch_pc_unit #(.WIDTH_PC(32), .RESET_PC(32'h4000_0000), .HALT_WORD(32'hFFFF_FFFF)) dut_hi (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_instr(i_instr),
    .i_branch(i_branch), .i_zero(i_zero), .i_jump(i_jump),
    .o_pc(pc1), .o_instr_valid(v1), .o_opcode(op1), .o_rs(rs1), .o_rt(rt1),
    .o_rd(rd1), .o_funct(fn1), .o_imm(im1), .o_halted(h1)
`ifdef FETCH_RETIRE_CNT_EN
    , .o_retired(ret1)
`endif
  );

  fetch_pc_unit #(.WIDTH_PC(32), .RESET_PC(32'hFFFF_FFFC), .HALT_WORD(32'hFFFF_FFFF)) dut_wr (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_instr(i_instr),
    .i_branch(i_branch), .i_zero(i_zero), .i_jump(i_jump),
    .o_pc(pc2), .o_instr_valid(v2), .o_opcode(op2), .o_rs(rs2), .o_rt(rt2),
    .o_rd(rd2), .o_funct(fn2), .o_imm(im2), .o_halted(h2)
`ifdef FETCH_RETIRE_CNT_EN
    , .o_retired(ret2)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        br;
    logic        zr;
    logic        jp;
    logic [42:0] fields;
    logic [31:0] nxt;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic reset_all();
    i_rst = 1'b1; i_start = 1'b0; i_branch = 1'b0; i_zero = 1'b0; i_jump = 1'b0;
    i_instr = 32'h0000_0000;
    #3;
    i_rst = 1'b0;
    tick();
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // pc, instr, branch, zero, jump, {op,rs,rt,rd,funct,imm}, next pc
    tbl[0] = '{32'h00, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 43'd0, 32'h04};
    tbl[1] = '{32'h04, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 43'd0, 32'h08};
    tbl[2] = '{32'h08, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 43'd0, 32'h0C};
    tbl[3] = '{32'h0C, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 43'd0, 32'h10};
    tbl[4] = '{32'h10, 32'h1022_FFFE, 1'b1, 1'b1, 1'b0,
               {6'h04, 5'd1, 5'd2, 5'd31, 6'h3E, 16'hFFFE}, 32'h0C};
    tbl[5] = '{32'h0C, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 43'd0, 32'h10};
    tbl[6] = '{32'h10, 32'h1022_FFFE, 1'b1, 1'b0, 1'b0,
               {6'h04, 5'd1, 5'd2, 5'd31, 6'h3E, 16'hFFFE}, 32'h14};
    tbl[7] = '{32'h14, 32'h0022_1820, 1'b0, 1'b0, 1'b0,
               {6'h00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h1820}, 32'h18};
    tbl[8] = '{32'h18, 32'h0800_0008, 1'b1, 1'b1, 1'b1,
               {6'h02, 5'd0, 5'd0, 5'd0, 6'h08, 16'h0008}, 32'h20};

    // Reset state, checked before any clock edge
    i_rst = 1'b1; i_start = 1'b0; i_instr = 32'h0022_1820;
    i_branch = 1'b0; i_zero = 1'b0; i_jump = 1'b0;
    #2;
    check("rst_pc0", pc0, 32'h0000_0000);
    check("rst_pc_hi", pc1, 32'h4000_0000);
    check("rst_pc_wr", pc2, 32'hFFFF_FFFC);
    check("rst_valid_halt", {v0, h0}, 2'b00);
    check("rst_fields", f0, 43'd0);
`ifdef FETCH_RETIRE_CNT_EN
    check("rst_retired", ret0, 32'd0);
`endif
    tick();
    i_rst = 1'b0;
    i_instr = 32'h0000_0000;
    tick();
    check("idle_pc", pc0, 32'h0000_0000);
    check("idle_valid", v0, 1'b0);

    start_pulse();
    check("run_first_pc", pc0, 32'h0000_0000);

    // Table-driven main run
    for (int i = 0; i < 9; i++) begin
      i_instr = tbl[i].instr; i_branch = tbl[i].br; i_zero = tbl[i].zr; i_jump = tbl[i].jp;
      #1;
      check($sformatf("vec%0d_pc", i), pc0, tbl[i].pc);
      check($sformatf("vec%0d_valid", i), v0, 1'b1);
      check($sformatf("vec%0d_fields", i), f0, tbl[i].fields);
      tick();
      check($sformatf("vec%0d_next", i), pc0, tbl[i].nxt);
    end
    i_branch = 1'b0; i_zero = 1'b0; i_jump = 1'b0;

    // Halt word at 0x20
    i_instr = 32'hFFFF_FFFF;
    #1;
    check("halt_cyc_valid", v0, 1'b0);
    check("halt_cyc_fields", f0, 43'd0);
    check("halt_cyc_halted", h0, 1'b0);
    tick();
    check("halt_halted", h0, 1'b1);
    check("halt_pc", pc0, 32'h20);
    i_instr = 32'h0000_0000;
    for (int c = 0; c < 10; c++) begin
      i_start = (c % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check($sformatf("halt_hold%0d", c), {h0, v0, pc0}, {1'b1, 1'b0, 32'h20});
    end
    i_start = 1'b0;
`ifdef FETCH_RETIRE_CNT_EN
    check("halt_retired", ret0, 32'd9);
`endif

    // Twelve NOPs, then asynchronous reset between edges at PC=0x30
    reset_all();
    start_pulse();
    for (int c = 0; c < 12; c++) tick();
    check("pre_rst_pc", pc0, 32'h30);
`ifdef FETCH_RETIRE_CNT_EN
    check("pre_rst_retired", ret0, 32'd12);
`endif
    i_instr = 32'h0022_1820;
    #1;
    check("pre_rst_valid", v0, 1'b1);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_pc", pc0, 32'h0000_0000);
    check("mid_rst_valid", v0, 1'b0);
    check("mid_rst_fields", f0, 43'd0);
`ifdef FETCH_RETIRE_CNT_EN
    check("mid_rst_retired", ret0, 32'd0);
`endif
    i_rst = 1'b0;
    i_instr = 32'h0000_0000;
    tick();
    check("post_rst_idle_pc", pc0, 32'h0000_0000);
    check("post_rst_idle_valid", v0, 1'b0);
    // i_start held high: only the first edge matters
    i_start = 1'b1;
    tick();
    check("hold_start_e1", pc0, 32'h0);
    tick();
    check("hold_start_e2", pc0, 32'h4);
    tick();
    check("hold_start_e3", pc0, 32'h8);
    i_start = 1'b0;

    // Wrap from 0xFFFF_FFFC; sequential step from 0x4000_0000
    reset_all();
    start_pulse();
    i_instr = 32'h0000_0000;
    #1;
    check("wr_first_pc", pc2, 32'hFFFF_FFFC);
    tick();
    check("wr_wrap_pc", pc2, 32'h0000_0000);
    check("hi_seq_pc", pc1, 32'h4000_0004);

    // Jump alone from 0x4000_0000
    reset_all();
    start_pulse();
    i_instr = 32'h0800_0040; i_jump = 1'b1;
    #1;
    check("hi_jmp_fields", {v1, h1, f1}, {1'b1, 1'b0, 6'h02, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0040});
    check("wr_jmp_fields", {v2, h2, f2}, {1'b1, 1'b0, 6'h02, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0040});
    tick();
    check("hi_jmp_pc", pc1, 32'h4000_0100);
    check("wr_jmp_pc", pc2, 32'h0000_0100);
`ifdef FETCH_RETIRE_CNT_EN
    check("hi_jmp_retired", ret1, 32'd1);
    check("wr_jmp_retired", ret2, 32'd1);
`endif

    // Jump together with taken branch: jump wins
    reset_all();
    start_pulse();
    i_instr = 32'h0800_0040; i_jump = 1'b1; i_branch = 1'b1; i_zero = 1'b1;
    tick();
    check("hi_jmp_br_pc", pc1, 32'h4000_0100);
    i_jump = 1'b0;
    // Taken branch from 0x4000_0100, imm=0x0040 -> 0x4000_0104 + 0x100
    tick();
    check("hi_br_pc", pc1, 32'h4000_0204);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
